prefix_sub32_pipe: RTL and testbench

//  Pipelined 32-bit parallel-prefix (Kogge-Stone) subtractor: diff = a - b - bin.

---
 rtl/prefix_sub32_pipe.sv | 141 ++++++++++++++
 tb/tb_prefix_sub32_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/prefix_sub32_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor: diff = a - b - bin, with borrow and signed-overflow flags.
// Optional feature macro SUB_SATURATE_EN: clamps diff to zero whenever a borrow occurs.
module prefix_sub32_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  // Prefix vectors are WIDTH bits: index 0 is the folded carry-in (bit -1), index k is bit k-1.
  // Bit WIDTH-1 never feeds the prefix tree; its carry-out term is formed from the sign bits.
  function automatic logic [WIDTH-1:0] gen_lvl(input logic [WIDTH-1:0] g,
                                               input logic [WIDTH-1:0] p,
                                               input int unsigned span);
    return g | (p & (g << span));
  endfunction

  function automatic logic [WIDTH-1:0] prop_lvl(input logic [WIDTH-1:0] p,
                                                input int unsigned span);
    return p & (p << span);
  endfunction

  logic s1_valid, s2_valid, s3_valid, run;
  logic s1_load, s2_load, s3_load;

  assign s3_load   = ~s3_valid | out_ready;
  assign s2_load   = ~s2_valid | s3_load;
  assign s1_load   = ~s1_valid | s2_load;
  assign in_ready  = run & s1_load;
  assign out_valid = s3_valid;

  // Stage 1 inputs: subtraction as a + ~b + ~bin.
  logic [WIDTH-1:0] p_in, g_in;
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitpg
    assign p_in[gi] = a[gi] ^ ~b[gi];
    assign g_in[gi] = a[gi] & ~b[gi];
  end

  logic [WIDTH-1:0] s1_p, s1_g;
  logic             s1_sa, s1_sb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_sa    <= 1'b0;
      s1_sb    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (s1_load) s1_valid <= in_valid & run;
      if (in_valid & in_ready) begin
        s1_p  <= p_in;
        s1_g  <= {g_in[WIDTH-2:0], ~bin};
        s1_sa <= a[WIDTH-1];
        s1_sb <= b[WIDTH-1];
      end
    end
  end

  // Stage 2: prefix levels of span 1, 2, 4.
  logic [WIDTH-1:0] g1, p1, g2, p2, g4, p4, p0;
  always_comb begin
    p0 = {s1_p[WIDTH-2:0], 1'b0};
    g1 = gen_lvl(s1_g, p0, 1);
    p1 = prop_lvl(p0, 1);
    g2 = gen_lvl(g1, p1, 2);
    p2 = prop_lvl(p1, 2);
    g4 = gen_lvl(g2, p2, 4);
    p4 = prop_lvl(p2, 4);
  end

  logic [WIDTH-1:0] s2_g, s2_p, s2_psum;
  logic             s2_sa, s2_sb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_g     <= '0;
      s2_p     <= '0;
      s2_psum  <= '0;
      s2_sa    <= 1'b0;
      s2_sb    <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_g    <= g4;
        s2_p    <= p4;
        s2_psum <= s1_p;
        s2_sa   <= s1_sa;
        s2_sb   <= s1_sb;
      end
    end
  end

  // Stage 3: levels of span 8, 16, then sum bits and flags.
  logic [WIDTH-1:0] g8, p8, carry, diff_mod, diff_d;
  logic             cout, bout_d, ovf_d;
  always_comb begin
    g8       = gen_lvl(s2_g, s2_p, 8);
    p8       = prop_lvl(s2_p, 8);
    carry    = gen_lvl(g8, p8, 16);
    diff_mod = s2_psum ^ carry;
    cout     = (s2_sa & ~s2_sb) | (s2_psum[WIDTH-1] & carry[WIDTH-1]);
    bout_d   = ~cout;
    ovf_d    = (s2_sa != s2_sb) & (diff_mod[WIDTH-1] != s2_sa);
`ifdef SUB_SATURATE_EN
    diff_d   = bout_d ? '0 : diff_mod;
`else
    diff_d   = diff_mod;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (s3_load) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        diff <= diff_d;
        bout <= bout_d;
        ovf  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_prefix_sub32_pipe.sv
// Self-checking bench for prefix_sub32_pipe: vector table, random stream with backpressure,
// stall/fill, latency and mid-flight reset sequences, all scored through an expected-result queue.
module tb_prefix_sub32_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        ovf;
  } vec_t;

`ifdef SUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, bin, out_valid, out_ready, bout, ovf;
  logic [31:0] a, b, diff;

  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  vec_t sb[$];
  vec_t tbl[8];

  prefix_sub32_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] va, vb, input logic vbin,
                              input logic [31:0] vd, input logic vbo, vov);
    vec_t v;
    v.a = va; v.b = vb; v.bin = vbin; v.bout = vbo; v.ovf = vov;
    v.d = (SAT && vbo) ? 32'h0 : vd;
    return v;
  endfunction

  // Reference: plain 33-bit subtraction, borrow is the wrapped top bit.
  function automatic vec_t model(input logic [31:0] va, vb, input logic vbin);
    logic [32:0] r;
    r = {1'b0, va} - {1'b0, vb} - {32'h0, vbin};
    return mk(va, vb, vbin, r[31:0], r[32], (va[31] != vb[31]) && (r[31] != va[31]));
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Caller is positioned just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v);
    bit ok = 1'b0;
    in_valid = 1'b1; a = v.a; b = v.b; bin = v.bin;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(v);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout a=%h b=%h got=in_ready_low want=accept", v.a, v.b);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_pending", sb.size(), 0);
  endtask

  // Output monitor: every valid output cycle is compared, so held results are checked too.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got diff=%h bout=%b want=no_output", diff, bout);
      end else begin
        if (diff !== sb[0].d || bout !== sb[0].bout || ovf !== sb[0].ovf) begin
          errors++;
          $display("FAIL result#%0d a=%h b=%h bin=%b got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                   n_out, sb[0].a, sb[0].b, sb[0].bin, diff, bout, ovf, sb[0].d, sb[0].bout, sb[0].ovf);
        end
        if (out_ready) begin
          $display("out #%0d a=%h b=%h bin=%b diff=%h bout=%b ovf=%b",
                   n_out, sb[0].a, sb[0].b, sb[0].bin, diff, bout, ovf);
          void'(sb.pop_front());
          n_out++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL global_timeout got=running want=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    tbl[0] = mk(32'hD573235A, 32'h39A4BE05, 1'b0, 32'h9BCE6555, 1'b0, 1'b0);
    tbl[1] = mk(32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    tbl[2] = mk(32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    tbl[3] = mk(32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    tbl[4] = mk(32'h0000000A, 32'h00000003, 1'b1, 32'h00000006, 1'b0, 1'b0);
    tbl[5] = mk(32'h00000005, 32'h00000009, 1'b0, 32'hFFFFFFFC, 1'b1, 1'b0);
    tbl[6] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    tbl[7] = mk(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_diff", diff, 0);
    chk("rst_flags", {bout, ovf}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_before_first_edge", in_ready, 0);
    @(negedge clk);
    chk("in_ready_after_release", in_ready, 1);
    @(posedge clk); #1;

    // T1 latency: result visible three cycles after the accept cycle
    in_valid = 1'b1; a = tbl[0].a; b = tbl[0].b; bin = tbl[0].bin;
    @(negedge clk);
    chk("t1_accept", in_ready, 1);
    sb.push_back(tbl[0]);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk("t1_lat_c1", out_valid, 0);
    @(negedge clk); chk("t1_lat_c2", out_valid, 0);
    @(negedge clk); chk("t1_lat_c3", out_valid, 1);
    @(posedge clk); #1;
    drain();

    // Vector table, back to back
    for (int i = 0; i < 8; i++) send(tbl[i]);
    drain();

    // Random stream with random backpressure
    fork
      begin
        for (int i = 0; i < 30; i++)
          send(model($urandom, $urandom, 1'($urandom_range(0, 1))));
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // T4: fill with output stalled, then release with pipe full
    @(posedge clk); #1 out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(model(32'h1000 * (i + 1), 32'h11 * i, i[0]));
      end
      begin
        repeat (6) @(negedge clk);
        chk("t4_full_in_ready", in_ready, 0);
        chk("t4_held_count", sb.size(), 3);
        chk("t4_out_valid_held", out_valid, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("t4_retire_and_enter", in_ready, 1);
      end
    join
    drain();
    chk("t4_total_out", n_out, 1 + 8 + 30 + 5);

    // T5: reset with two operations in flight
    send(tbl[1]);
    send(tbl[2]);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_out_valid_in_reset", out_valid, 0);
    chk("t5_in_ready_in_reset", in_ready, 0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;

    // Pipeline still works after reset
    send(tbl[5]);
    send(tbl[7]);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
